d_cache: RTL and testbench

//   Set-associative, write-back, write-allocate L1 data cache between the core load/store unit and a

---
 rtl/d_cache_if.sv | 26 ++
 rtl/d_cache.sv | 158 +++++++++++++++
 tb/tb_d_cache.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_if.sv
// d_cache_if: load/store request and block memory port bundle shared by d_cache and its environment
interface d_cache_if #(
    parameter int BLOCK_SIZE = 8
);
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [31:0]             writeData;
    logic [2:0]              strobe;
    logic [31:0]             readData;
    logic                    valid;
    logic                    memBusy;
    logic [31:0]             memAddress;
    logic                    memRead;
    logic [BLOCK_SIZE*8-1:0] memReadData;
    logic                    memWrite;
    logic [BLOCK_SIZE*8-1:0] memWriteData;
    modport master (
        output address, read, write, writeData, strobe, memBusy, memReadData,
        input  readData, valid, memAddress, memRead, memWrite, memWriteData
    );
    modport slave (
        input  address, read, write, writeData, strobe, memBusy, memReadData,
        output readData, valid, memAddress, memRead, memWrite, memWriteData
    );
endinterface

// File: rtl/d_cache.sv
// d_cache: set-associative write-back write-allocate L1 data cache; DCACHE_PERF_CNT_EN adds hitCount/missCount
module d_cache #(
    parameter int BLOCK_SIZE    = 8,
    parameter int TOTAL_LINES   = 256,
    parameter int ASSOCIATIVITY = 4
) (
    input logic      clk,
    input logic      rst,
    d_cache_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);
    localparam int OFF  = $clog2(BLOCK_SIZE);
    localparam int SETS = TOTAL_LINES / ASSOCIATIVITY;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = 32 - IDX - OFF;
    localparam int WW   = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
    localparam int LW   = BLOCK_SIZE * 8;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT} state_t;
    typedef logic [ASSOCIATIVITY-1:0][WW-1:0] ages_t;

    function automatic ages_t init_age();
        ages_t r;
        for (int w = 0; w < ASSOCIATIVITY; w++) r[w] = WW'(w);
        return r;
    endfunction

    state_t                                  state, nxt;
    logic   [SETS-1:0][ASSOCIATIVITY-1:0]    vld, drt;
    ages_t  [SETS-1:0]                       age;
    logic   [TAG-1:0]                        tags [SETS][ASSOCIATIVITY];
    logic   [LW-1:0]                         data [SETS][ASSOCIATIVITY];
    logic   [31:0]                           rd_q, rd_val, w;
    logic   [WW-1:0]                         hw, vic, vic_q;
    logic   [IDX-1:0]                        idx;
    logic   [TAG-1:0]                        tg;
    logic   [OFF-1:0]                        off, off_a;
    logic   [OFF+2:0]                        sh;
    logic   [LW-1:0]                         line, msk, merged;
    ages_t                                   age_nx;
    logic                                    hit, found, req, hit_ok, miss, fill, fill_done;

    assign idx       = bus.address[IDX+OFF-1:OFF];
    assign tg        = bus.address[31:IDX+OFF];
    assign off       = bus.address[OFF-1:0];
    assign req       = bus.read | bus.write;
    assign hit_ok    = state == IDLE && req && hit;
    assign miss      = state == IDLE && req && !hit;
    assign fill      = state == REFILL_REQ || state == REFILL_WAIT;
    assign fill_done = state == REFILL_WAIT && !bus.memBusy;

    always_comb begin
        hit   = 1'b0;
        hw    = '0;
        vic   = '0;
        found = 1'b0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (vld[idx][w] && tags[idx][w] == tg) begin
                hit = 1'b1;
                hw  = WW'(w);
            end
            if (!found && !vld[idx][w]) begin
                vic   = WW'(w);
                found = 1'b1;
            end
        end
        // with every way valid, evict the oldest
        if (!found)
            for (int w = 0; w < ASSOCIATIVITY; w++)
                if (age[idx][w] > age[idx][vic]) vic = WW'(w);
        for (int w = 0; w < ASSOCIATIVITY; w++)
            age_nx[w] = (WW'(w) == hw) ? '0 :
                        (age[idx][w] < age[idx][hw]) ? age[idx][w] + 1'b1 : age[idx][w];
    end

    always_comb begin
        line   = data[idx][hw];
        off_a  = bus.strobe[1] ? {off[OFF-1:2], 2'b00} : bus.strobe[0] ? {off[OFF-1:1], 1'b0} : off;
        sh     = {off_a, 3'b000};
        w      = 32'(line >> sh);
        rd_val = bus.strobe[1] ? w :
                 bus.strobe[0] ? (bus.strobe[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]}) :
                                 (bus.strobe[2] ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]});
        msk    = LW'(bus.strobe[1] ? 32'hffff_ffff : bus.strobe[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
        merged = (line & ~msk) | ((LW'(bus.writeData) << sh) & msk);
    end

    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:        if (miss) nxt = (vld[idx][vic] && drt[idx][vic]) ? WRITEBACK : REFILL_REQ;
            WRITEBACK:   if (!bus.memBusy) nxt = REFILL_REQ;
            REFILL_REQ:  if (bus.memBusy) nxt = REFILL_WAIT;
            REFILL_WAIT: if (!bus.memBusy) nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.valid        = hit_ok;
        bus.readData     = hit_ok ? rd_val : rd_q;
        bus.memWrite     = state == WRITEBACK;
        bus.memRead      = fill;
        bus.memAddress   = state == WRITEBACK ? {tags[idx][vic_q], idx, {OFF{1'b0}}} :
                           fill ? {bus.address[31:OFF], {OFF{1'b0}}} : '0;
        bus.memWriteData = state == WRITEBACK ? data[idx][vic_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld   <= '0;
            drt   <= '0;
            age   <= {SETS{init_age()}};
            rd_q  <= '0;
            vic_q <= '0;
        end else begin
            if (hit_ok) begin
                rd_q     <= rd_val;
                age[idx] <= age_nx;
                if (bus.write) drt[idx][hw] <= 1'b1;
            end
            if (miss) vic_q <= vic;
            if (fill_done) begin
                vld[idx][vic_q] <= 1'b1;
                drt[idx][vic_q] <= 1'b0;
            end
        end
    end

    // arrays carry no reset: vld alone decides whether a line means anything
    always_ff @(posedge clk)
        if (rst) begin
            if (hit_ok && bus.write) data[idx][hw] <= merged;
            if (fill_done) begin
                data[idx][vic_q] <= bus.memReadData;
                tags[idx][vic_q] <= tg;
            end
        end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk)
        if (!rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (hit_ok) hitCount  <= hitCount + 1'b1;
            if (miss)   missCount <= missCount + 1'b1;
        end
`endif
endmodule

// File: tb/tb_d_cache.sv
// tb_d_cache: directed and randomized accesses checked against an LRU queue model of the cache
module tb_d_cache;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    d_cache_if #(.BLOCK_SIZE(8)) bus();
    d_cache #(.BLOCK_SIZE(8), .TOTAL_LINES(256), .ASSOCIATIVITY(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {
        logic [22:0] tag;
        logic        dirty;
        logic [63:0] data;
    } mline_t;

    mline_t      mset [64][$];
    logic [63:0] mem [logic [28:0]];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] got, last_rd, a;
    logic        last_was_rd = 1'b0;
    logic [2:0]  sts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] blk(input logic [28:0] b);
        if (!mem.exists(b)) mem[b] = {$urandom, $urandom};
        return mem[b];
    endfunction

    // each set is a recency list, most recent first, at most four lines
    task automatic model(input logic [31:0] ad, input logic wr, input logic [2:0] st, input logic [31:0] wd,
                         output logic hit, output logic wb, output logic [31:0] wba,
                         output logic [63:0] wbd, output logic [31:0] rd);
        logic [5:0]  s;
        mline_t      ln, v;
        logic [63:0] d;
        int          pos, n, base;
        s   = ad[8:3];
        pos = -1;
        wb  = 1'b0;
        wba = '0;
        wbd = '0;
        rd  = '0;
        for (int i = 0; i < mset[s].size(); i++) if (mset[s][i].tag == ad[31:9]) pos = i;
        hit = pos >= 0;
        if (hit) begin
            ln = mset[s][pos];
            mset[s].delete(pos);
        end else begin
            if (mset[s].size() == 4) begin
                v = mset[s].pop_back();
                if (v.dirty) begin
                    wb  = 1'b1;
                    wba = {v.tag, s, 3'b000};
                    wbd = v.data;
                    mem[wba[31:3]] = v.data;
                end
            end
            ln.tag   = ad[31:9];
            ln.dirty = 1'b0;
            ln.data  = blk(ad[31:3]);
        end
        n    = st[1] ? 4 : st[0] ? 2 : 1;
        base = (int'(ad[2:0]) / n) * n;
        d    = ln.data;
        for (int i = 0; i < n; i++) rd[8*i +: 8] = d[8*(base+i) +: 8];
        if (!st[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hffff_ffff << (8*n));
        if (wr) begin
            for (int i = 0; i < n; i++) d[8*(base+i) +: 8] = wd[8*i +: 8];
            ln.data  = d;
            ln.dirty = 1'b1;
        end
        mset[s].push_front(ln);
    endtask

    task automatic access(input logic [31:0] ad, input logic wr, input logic both, input logic [2:0] st,
                          input logic [31:0] wd, output logic [31:0] rdata);
        logic        hit, wb, done, seen, wseen;
        logic [31:0] wba, exp_rd;
        logic [63:0] wbd;
        int          cyc, wbn;
        model(ad, wr, st, wd, hit, wb, wba, wbd, exp_rd);
        bus.address   = ad;
        bus.read      = !wr || both;
        bus.write     = wr;
        bus.strobe    = st;
        bus.writeData = wd;
        {done, seen, wseen} = '0;
        cyc   = 0;
        wbn   = 0;
        rdata = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.memBusy = 1'b0;
            if (bus.valid) begin
                done  = 1'b1;
                rdata = bus.readData;
            end else if (bus.memWrite) begin
                if (!wseen) begin
                    chk("wb_addr", bus.memAddress, wba);
                    chk("wb_data", bus.memWriteData, wbd);
                end
                wseen       = 1'b1;
                bus.memBusy = $urandom_range(0, 1) == 1;
                if (!bus.memBusy) wbn++;
            end else if (bus.memRead) begin
                if (!seen) chk("refill_addr", bus.memAddress, {ad[31:3], 3'b000});
                bus.memReadData = blk(ad[31:3]);
                bus.memBusy     = !seen || $urandom_range(0, 2) == 0;
                seen            = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.memBusy = 1'b0;
        chk("complete", done, 1);
        chk("miss", seen, !hit);
        chk("writeback_count", wbn, wb);
        if (hit) chk("hit_latency", cyc, 1);
        if (!wr) chk("readData", rdata, exp_rd);
        last_rd     = rdata;
        last_was_rd = !wr;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_valid", bus.valid, 0);
        if (last_was_rd) chk("readData_hold", bus.readData, last_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_readData"}, bus.readData, 0);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_memRead"}, bus.memRead, 0);
        chk({tag, "_memWrite"}, bus.memWrite, 0);
        chk({tag, "_memAddress"}, bus.memAddress, 0);
        chk({tag, "_memWriteData"}, bus.memWriteData, 0);
    endtask

    initial begin
        int n, c;
        logic wr;
        bus.address     = '0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.writeData   = '0;
        bus.strobe      = '0;
        bus.memBusy     = 1'b0;
        bus.memReadData = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        zero_check("reset");
        @(posedge clk);
        #1;

        mem[29'h0000] = 64'hABCD123456789090;
        mem[29'h0200] = 64'hAAAAAAAAAABBCCAA;
        mem[29'h6200] = 64'hBBBBBBBBBBBBCCBB;
        access(32'h0000_0004, 1'b0, 1'b0, 3'b010, 32'h0, got);
        chk("s1_word", got, 32'hABCD1234);
        access(32'h0000_1005, 1'b0, 1'b0, 3'b100, 32'h0, got);
        chk("s2_ubyte", got, 32'h0000_00AA);
        access(32'h0000_1001, 1'b0, 1'b0, 3'b000, 32'h0, got);
        chk("s2_sbyte", got, 32'hFFFF_FFCC);
        idle_check();
        access(32'h0003_1005, 1'b1, 1'b0, 3'b000, 32'h49, got);
        access(32'h0003_1005, 1'b0, 1'b0, 3'b100, 32'h0, got);
        chk("s3_store_byte", got, 32'h0000_0049);
        access(32'h0005_1002, 1'b1, 1'b0, 3'b001, 32'h6767, got);
        access(32'h0000_0004, 1'b0, 1'b0, 3'b010, 32'h0, got);
        access(32'h3000_0004, 1'b0, 1'b0, 3'b010, 32'h0, got);
        access(32'h7000_1005, 1'b0, 1'b0, 3'b100, 32'h0, got);
        access(32'h9000_1001, 1'b0, 1'b0, 3'b000, 32'h0, got);
        idle_check();

        for (int i = 0; i < 250; i++) begin
            a  = {23'($urandom_range(0, 5) * 37 + 1), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            wr = $urandom_range(0, 2) == 0;
            access(a, wr, wr && $urandom_range(0, 3) == 0, sts[$urandom_range(0, 4)], $urandom, got);
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        a             = 32'hABC0_01F8;
        bus.address   = a;
        bus.strobe    = 3'b010;
        bus.read      = 1'b1;
        n             = 0;
        c             = 0;
        while (n < 2 && c < 20) begin
            @(negedge clk);
            c++;
            bus.memBusy = 1'b0;
            if (bus.memRead) begin
                n++;
                bus.memBusy = n == 1;
            end
            if (n < 2) begin
                @(posedge clk);
                #1;
            end
        end
        chk("abort_reached_wait", n, 2);
        bus.memReadData = 64'h1122334455667788;
        rst             = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.read = 1'b0;
        @(negedge clk);
        zero_check("abort");
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) mset[i].delete();
        last_was_rd = 1'b0;
        access(a, 1'b0, 1'b0, 3'b010, 32'h0, got);
        access(32'h0000_0004, 1'b0, 1'b0, 3'b010, 32'h0, got);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
